// File: rtl/dcache_wr_axi.sv
// Write-side AXI master for the data cache: buffers one line writeback or uncached
// store, then drives AW, W and B; also flags reads that hit the line being written.
module dcache_wr_axi #(
  parameter logic [3:0]  AXI_ID     = 4'd1,
  parameter int unsigned LINE_BEATS = 4
) (
  input  logic         aclk,
  input  logic         areset,
  // Dcache write interface
  input  logic         wr_req,
  input  logic [2:0]   wr_type,
  input  logic [31:0]  wr_addr,
  input  logic [3:0]   wr_wstrb,
  input  logic [127:0] wr_data,
  output logic         wr_rdy,
  // AXI write address channel
  output logic [3:0]   awid,
  output logic [31:0]  awaddr,
  output logic [7:0]   awlen,
  output logic [2:0]   awsize,
  output logic [1:0]   awburst,
  output logic [1:0]   awlock,
  output logic [3:0]   awcache,
  output logic [2:0]   awprot,
  output logic         awvalid,
  input  logic         awready,
  // AXI write data channel
  output logic [3:0]   wid,
  output logic [31:0]  wdata,
  output logic [3:0]   wstrb,
  output logic         wlast,
  output logic         wvalid,
  input  logic         wready,
  // AXI write response channel
  input  logic [3:0]   bid,
  input  logic [1:0]   bresp,
  input  logic         bvalid,
  output logic         bready,
  // Read-after-write conflict check
  input  logic [31:0]  rd_chk_addr,
  output logic         rd_conflict,
  output logic         wr_busy
);

  localparam int unsigned CntW = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;

  typedef enum logic [1:0] {StIdle, StAw, StW, StB} state_e;

  state_e         state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]     type_q;
  logic [31:0]    addr_q;
  logic [3:0]     wstrb_q;
  logic [127:0]   data_q;
  logic           capture;

  logic           is_line;
  logic [7:0]     len;
  logic [2:0]     size;
  logic           last_beat;
  logic           unused_inputs;

  assign is_line   = (type_q == 3'b100);
  assign len       = is_line ? 8'(LINE_BEATS - 1) : 8'd0;
  assign size      = is_line ? 3'b010 : {1'b0, type_q[1:0]};
  assign last_beat = (8'(cnt_q) == len);

  // Response id/status are not checked; a single outstanding write needs neither.
  assign unused_inputs = ^{bid, bresp, rd_chk_addr[3:0]};

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      type_q  <= '0;
      addr_q  <= '0;
      wstrb_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        type_q  <= wr_type;
        addr_q  <= wr_addr;
        wstrb_q <= wr_wstrb;
        data_q  <= wr_data;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (wr_req) begin
          capture = 1'b1;
          state_d = StAw;
        end
      end
      StAw: begin
        if (awready) begin
          cnt_d   = '0;
          state_d = StW;
        end
      end
      StW: begin
        if (wready) begin
          cnt_d = cnt_q + 1'b1;
          if (last_beat) state_d = StB;
        end
      end
      StB: begin
        if (bvalid) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Channel fields are zeroed outside their own state so idle outputs read 0.
  always_comb begin
    wr_rdy  = 1'b0;
    awid    = '0;
    awaddr  = '0;
    awlen   = '0;
    awsize  = '0;
    awburst = '0;
    awlock  = '0;
    awcache = '0;
    awprot  = '0;
    awvalid = 1'b0;
    wid     = '0;
    wdata   = '0;
    wstrb   = '0;
    wlast   = 1'b0;
    wvalid  = 1'b0;
    bready  = 1'b0;
    unique case (state_q)
      StIdle: wr_rdy = 1'b1;
      StAw: begin
        awid    = AXI_ID;
        awaddr  = addr_q;
        awlen   = len;
        awsize  = size;
        awburst = 2'b01;
        awvalid = 1'b1;
      end
      StW: begin
        wid    = AXI_ID;
        wdata  = data_q[{cnt_q, 5'b0} +: 32];
        wstrb  = is_line ? 4'hF : wstrb_q;
        wlast  = last_beat;
        wvalid = 1'b1;
      end
      StB: bready = 1'b1;
      default: ;
    endcase
  end

  assign wr_busy     = (state_q != StIdle);
  assign rd_conflict = wr_busy && (rd_chk_addr[31:4] == addr_q[31:4]);

endmodule

// File: tb/tb_dcache_wr_axi.sv
// Directed self-checking bench for dcache_wr_axi; inputs change and outputs are
// sampled on the falling clock edge.
module tb_dcache_wr_axi;

  logic         aclk = 1'b0;
  logic         areset;
  logic         wr_req;
  logic [2:0]   wr_type;
  logic [31:0]  wr_addr;
  logic [3:0]   wr_wstrb;
  logic [127:0] wr_data;
  logic         wr_rdy;
  logic [3:0]   awid;
  logic [31:0]  awaddr;
  logic [7:0]   awlen;
  logic [2:0]   awsize;
  logic [1:0]   awburst;
  logic [1:0]   awlock;
  logic [3:0]   awcache;
  logic [2:0]   awprot;
  logic         awvalid;
  logic         awready;
  logic [3:0]   wid;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         wlast;
  logic         wvalid;
  logic         wready;
  logic [3:0]   bid;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready;
  logic [31:0]  rd_chk_addr;
  logic         rd_conflict;
  logic         wr_busy;

  int checks = 0;
  int passes = 0;

  always #5 aclk = ~aclk;

  dcache_wr_axi dut (
    .aclk        (aclk),
    .areset      (areset),
    .wr_req      (wr_req),
    .wr_type     (wr_type),
    .wr_addr     (wr_addr),
    .wr_wstrb    (wr_wstrb),
    .wr_data     (wr_data),
    .wr_rdy      (wr_rdy),
    .awid        (awid),
    .awaddr      (awaddr),
    .awlen       (awlen),
    .awsize      (awsize),
    .awburst     (awburst),
    .awlock      (awlock),
    .awcache     (awcache),
    .awprot      (awprot),
    .awvalid     (awvalid),
    .awready     (awready),
    .wid         (wid),
    .wdata       (wdata),
    .wstrb       (wstrb),
    .wlast       (wlast),
    .wvalid      (wvalid),
    .wready      (wready),
    .bid         (bid),
    .bresp       (bresp),
    .bvalid      (bvalid),
    .bready      (bready),
    .rd_chk_addr (rd_chk_addr),
    .rd_conflict (rd_conflict),
    .wr_busy     (wr_busy)
  );

  task automatic step();
    @(negedge aclk);
  endtask

  task automatic test_reset();
    step();
    checks++; if (wr_rdy !== 1'b1) $display("FAIL reset_wr_rdy got %b exp 1", wr_rdy); else passes++;
    checks++; if ({awvalid, wvalid, bready, wr_busy, rd_conflict} !== 5'b0)
      $display("FAIL reset_valids got %b exp 00000", {awvalid, wvalid, bready, wr_busy, rd_conflict});
    else passes++;
    checks++; if ({awid, awaddr, awlen, wid, wdata, wlast} !== '0)
      $display("FAIL reset_fields got %h exp 0", {awid, awaddr, awlen, wid, wdata, wlast});
    else passes++;
    areset = 1'b0;
  endtask

  // Always-ready slave; bvalid already high during W must not end the burst early.
  task automatic test_line();
    logic [31:0] beats [4] = '{32'h01234567, 32'hDEADBEEF, 32'h22221111, 32'h44443333};
    awready = 1'b1; wready = 1'b1; bvalid = 1'b1;
    wr_req = 1'b1; wr_type = 3'b100; wr_addr = 32'h1C000120; wr_wstrb = 4'h0;
    wr_data = 128'h44443333_22221111_DEADBEEF_01234567;
    step();
    wr_req = 1'b0;
    checks++; if ({awvalid, awaddr, awlen, awsize} !== {1'b1, 32'h1C000120, 8'd3, 3'd2})
      $display("FAIL line_aw got v=%b a=%h l=%0d s=%0d exp v=1 a=1c000120 l=3 s=2",
               awvalid, awaddr, awlen, awsize);
    else passes++;
    checks++; if ({awid, awburst, awlock, awcache, awprot, wvalid, wr_rdy} !== {4'd1, 2'b01, 9'd0, 2'b00})
      $display("FAIL line_aw_fixed got id=%h b=%b wv=%b rdy=%b", awid, awburst, wvalid, wr_rdy);
    else passes++;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if ({wvalid, wid, wdata, wstrb, wlast} !== {1'b1, 4'd1, beats[i], 4'hF, (i == 3)})
        $display("FAIL line_beat%0d got v=%b id=%h d=%h s=%h l=%b exp d=%h s=f l=%b",
                 i, wvalid, wid, wdata, wstrb, wlast, beats[i], (i == 3));
      else passes++;
    end
    step();
    checks++; if ({bready, wvalid, wr_rdy} !== 3'b100)
      $display("FAIL line_b got bready=%b wvalid=%b wr_rdy=%b exp 1 0 0", bready, wvalid, wr_rdy);
    else passes++;
    step();
    checks++; if ({wr_rdy, wr_busy} !== 2'b10)
      $display("FAIL line_latency7 got wr_rdy=%b busy=%b exp 1 0", wr_rdy, wr_busy);
    else passes++;
  endtask

  task automatic test_byte();
    awready = 1'b1; wready = 1'b1; bvalid = 1'b1;
    wr_req = 1'b1; wr_type = 3'b000; wr_addr = 32'h1FAF0003; wr_wstrb = 4'b1000;
    wr_data = {96'h0, 32'hAB000000};
    step();
    wr_req = 1'b0;
    checks++; if ({awvalid, awaddr, awlen, awsize} !== {1'b1, 32'h1FAF0003, 8'd0, 3'd0})
      $display("FAIL byte_aw got a=%h l=%0d s=%0d exp a=1faf0003 l=0 s=0", awaddr, awlen, awsize);
    else passes++;
    step();
    checks++; if ({wvalid, wdata, wstrb, wlast} !== {1'b1, 32'hAB000000, 4'h8, 1'b1})
      $display("FAIL byte_w got d=%h s=%h l=%b exp d=ab000000 s=8 l=1", wdata, wstrb, wlast);
    else passes++;
    step();
    checks++; if ({bready, wvalid} !== 2'b10)
      $display("FAIL byte_b got bready=%b wvalid=%b exp 1 0", bready, wvalid);
    else passes++;
    step();
    checks++; if (wr_rdy !== 1'b1) $display("FAIL byte_latency4 got %b exp 1", wr_rdy); else passes++;
  endtask

  task automatic test_backpressure();
    logic [31:0] beats [4] = '{32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3};
    int acc;
    int guard;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    wr_req = 1'b1; wr_type = 3'b100; wr_addr = 32'h00002000;
    wr_data = {beats[3], beats[2], beats[1], beats[0]};
    step();
    wr_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({awvalid, awaddr, awlen, wvalid} !== {1'b1, 32'h00002000, 8'd3, 1'b0})
        $display("FAIL bp_aw_hold%0d got v=%b a=%h l=%0d wv=%b", i, awvalid, awaddr, awlen, wvalid);
      else passes++;
      if (i == 3) awready = 1'b1;
      step();
    end
    awready = 1'b0;
    acc = 0;
    guard = 0;
    while (acc < 4 && guard < 20) begin
      wready = guard[0];
      checks++;
      if ({wvalid, wdata, wlast} !== {1'b1, beats[acc], (acc == 3)})
        $display("FAIL bp_w%0d got v=%b d=%h l=%b exp d=%h l=%b",
                 acc, wvalid, wdata, wlast, beats[acc], (acc == 3));
      else passes++;
      if (wready) acc++;
      guard++;
      step();
    end
    wready = 1'b0;
    checks++; if ({bready, wvalid, acc} !== {2'b10, 32'd4})
      $display("FAIL bp_beats got bready=%b wvalid=%b accepted=%0d exp 1 0 4", bready, wvalid, acc);
    else passes++;
    bvalid = 1'b1;
    step();
    bvalid = 1'b0;
    checks++; if (wr_rdy !== 1'b1) $display("FAIL bp_done got %b exp 1", wr_rdy); else passes++;
  endtask

  task automatic test_conflict();
    awready = 1'b0; wready = 1'b1; bvalid = 1'b1;
    wr_req = 1'b1; wr_type = 3'b100; wr_addr = 32'h00001230; wr_data = '1;
    step();
    wr_req = 1'b0;
    rd_chk_addr = 32'h0000123C;
    #1;
    checks++; if (rd_conflict !== 1'b1) $display("FAIL conflict_hit got %b exp 1", rd_conflict); else passes++;
    rd_chk_addr = 32'h00001240;
    #1;
    checks++; if (rd_conflict !== 1'b0) $display("FAIL conflict_miss got %b exp 0", rd_conflict); else passes++;
    awready = 1'b1;
    repeat (6) step();
    rd_chk_addr = 32'h00001230;
    #1;
    checks++; if ({wr_rdy, rd_conflict} !== 2'b10)
      $display("FAIL conflict_idle got rdy=%b conflict=%b exp 1 0", wr_rdy, rd_conflict);
    else passes++;
    rd_chk_addr = '0;
  endtask

  task automatic test_blocking();
    awready = 1'b1; wready = 1'b1; bvalid = 1'b0;
    wr_req = 1'b1; wr_type = 3'b010; wr_addr = 32'h00003000; wr_wstrb = 4'hF;
    wr_data = {96'h0, 32'h11112222};
    step();
    wr_addr = 32'h00004004;
    wr_data = {96'h0, 32'h33334444};
    checks++; if ({awaddr, wr_rdy} !== {32'h00003000, 1'b0})
      $display("FAIL block_first got a=%h rdy=%b exp 00003000 0", awaddr, wr_rdy);
    else passes++;
    step();
    checks++; if (wr_rdy !== 1'b0) $display("FAIL block_w got %b exp 0", wr_rdy); else passes++;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if ({wr_rdy, bready, awvalid} !== 3'b010)
        $display("FAIL block_b%0d got rdy=%b bready=%b awvalid=%b exp 0 1 0", i, wr_rdy, bready, awvalid);
      else passes++;
    end
    bvalid = 1'b1;
    step();
    bvalid = 1'b0;
    checks++; if (wr_rdy !== 1'b1) $display("FAIL block_idle got %b exp 1", wr_rdy); else passes++;
    step();
    wr_req = 1'b0;
    checks++; if ({awvalid, awaddr} !== {1'b1, 32'h00004004})
      $display("FAIL block_second got v=%b a=%h exp 1 00004004", awvalid, awaddr);
    else passes++;
    step();
    checks++; if (wdata !== 32'h33334444) $display("FAIL block_second_w got %h exp 33334444", wdata); else passes++;
    bvalid = 1'b1;
    step();
    step();
    bvalid = 1'b0;
    checks++; if (wr_rdy !== 1'b1) $display("FAIL block_done got %b exp 1", wr_rdy); else passes++;
  endtask

  task automatic test_reset_mid();
    awready = 1'b1; wready = 1'b1; bvalid = 1'b0;
    wr_req = 1'b1; wr_type = 3'b100; wr_addr = 32'h00005000; wr_data = '0;
    step();
    wr_req = 1'b0;
    repeat (3) step();
    checks++; if ({wvalid, wr_busy} !== 2'b11) $display("FAIL rst_mid_beat3 got %b exp 11", {wvalid, wr_busy});
    else passes++;
    areset = 1'b1;
    #1;
    checks++; if ({awvalid, wvalid, bready, wr_rdy, wr_busy} !== 5'b00010)
      $display("FAIL rst_mid_async got aw=%b w=%b b=%b rdy=%b busy=%b exp 0 0 0 1 0",
               awvalid, wvalid, bready, wr_rdy, wr_busy);
    else passes++;
    step();
    areset = 1'b0;
    wr_req = 1'b1; wr_type = 3'b010; wr_addr = 32'h00006008; wr_wstrb = 4'hF;
    step();
    wr_req = 1'b0;
    checks++; if ({awvalid, awaddr, awlen, awsize} !== {1'b1, 32'h00006008, 8'd0, 3'd2})
      $display("FAIL rst_mid_fresh got v=%b a=%h l=%0d s=%0d exp 1 00006008 0 2",
               awvalid, awaddr, awlen, awsize);
    else passes++;
    bvalid = 1'b1;
    repeat (3) step();
    bvalid = 1'b0;
    checks++; if (wr_rdy !== 1'b1) $display("FAIL rst_mid_done got %b exp 1", wr_rdy); else passes++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    areset = 1'b1;
    wr_req = 1'b0; wr_type = '0; wr_addr = '0; wr_wstrb = '0; wr_data = '0;
    awready = 1'b0; wready = 1'b0; bid = '0; bresp = '0; bvalid = 1'b0;
    rd_chk_addr = '0;
    test_reset();
    test_line();
    test_byte();
    test_backpressure();
    test_conflict();
    test_blocking();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
